// File: rtl/t5_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : t5_result_packer
// Brief    : Packs 2-bit t_5 results into words, buffers them in a word FIFO
//            and emits each word with its valid-pair count; flush emits a
//            partially filled word.
// Revision : 1.0
// ============================================================================
module t5_result_packer #(
    parameter int PAIRS      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              po0,
    input  logic                              po1,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [2*PAIRS-1:0]                out_data,
    output logic [$clog2(PAIRS+1)-1:0]        out_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]                  pairs_total
);

    localparam int c_cw = $clog2(PAIRS + 1);
    localparam int c_lw = $clog2(FIFO_DEPTH + 1);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_dw = 2 * PAIRS;

    localparam logic [c_cw-1:0] c_last_slot = c_cw'(PAIRS - 1);
    localparam logic [c_lw-1:0] c_depth     = c_lw'(FIFO_DEPTH);

    logic [c_dw-1:0]  r_pack;
    logic [c_cw-1:0]  r_fill;
    logic             r_flush_pending;
    logic [c_dw-1:0]  r_mem_data  [FIFO_DEPTH];
    logic [c_cw-1:0]  r_mem_count [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;
    logic [CNT_W-1:0] r_total;

    logic             w_full;
    logic             w_empty;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;
    logic [c_dw-1:0]  w_pack_next;
    logic [c_cw-1:0]  w_fill_next;
    logic             w_complete;
    logic             w_flush_push;
    logic             w_flush_done;
    logic             w_push;

    assign w_full     = (r_level == c_depth);
    assign w_empty    = (r_level == '0);
    assign w_in_ready = (r_fill != c_last_slot) || !w_full;
    assign w_accept   = in_valid && w_in_ready;
    assign w_pop      = !w_empty && out_ready;

    always_comb begin
        w_pack_next = r_pack;
        for (int k = 0; k < PAIRS; k++) begin
            if (w_accept && (r_fill == c_cw'(k))) begin
                w_pack_next[2*k +: 2] = {po1, po0};
            end
        end
    end

    assign w_fill_next = r_fill + {{(c_cw-1){1'b0}}, w_accept};
    assign w_complete  = w_accept && (r_fill == c_last_slot);

    // A completing accept already produces the word, so a pending flush
    // only pushes a partial word when the accept did not finish one.
    assign w_flush_push = r_flush_pending && !w_complete && (w_fill_next != '0) && !w_full;
    assign w_flush_done = r_flush_pending && (w_complete || w_flush_push || (w_fill_next == '0));
    assign w_push       = w_complete || w_flush_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack          <= '0;
            r_fill          <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            if (w_push) begin
                r_pack <= '0;
                r_fill <= '0;
            end else begin
                r_pack <= w_pack_next;
                r_fill <= w_fill_next;
            end

            if (w_flush_done) begin
                r_flush_pending <= 1'b0;
            end else if (flush) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_count[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr]  <= w_pack_next;
                r_mem_count[r_wr_ptr] <= w_fill_next;
                r_wr_ptr              <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lw'(1);
                2'b01:   r_level <= r_level - c_lw'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (w_accept && (r_total != '1)) begin
            r_total <= r_total + CNT_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = !w_empty;
    assign out_data    = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign out_count   = w_empty ? '0 : r_mem_count[r_rd_ptr];
    assign fifo_level  = r_level;
    assign pairs_total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_t5_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_t5_result_packer
// Brief    : Scoreboard bench for t5_result_packer (PAIRS=4, FIFO_DEPTH=4,
//            CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_t5_result_packer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       po0       = 1'b0;
    logic       po1       = 1'b0;
    logic       flush     = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_count;
    logic [2:0] fifo_level;
    logic [3:0] pairs_total;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] c;
    } word_t;

    word_t      q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_pack  = '0;
    int         m_fill  = 0;
    int         m_total = 0;
    int         n_acc   = 0;

    t5_result_packer #(
        .PAIRS      (4),
        .FIFO_DEPTH (4),
        .CNT_W      (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .po0         (po0),
        .po1         (po1),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .fifo_level  (fifo_level),
        .pairs_total (pairs_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] p, input logic f);
        in_valid   = v;
        {po1, po0} = p;
        flush      = f;
    endtask

    task automatic exp_flush();
        if (m_fill > 0) begin
            q.push_back({m_pack, 3'(m_fill)});
            m_pack = '0;
            m_fill = 0;
        end
    endtask

    // One clock: check outputs at the falling edge, note what the next rising
    // edge accepts, then return just after that rising edge.
    task automatic step();
        word_t e;
        @(negedge clk);
        chk("pairs_total", pairs_total, m_total);
        if (out_valid && out_ready) begin
            chk("word_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_count", out_count, e.c);
            end
        end
        if (in_valid && in_ready) begin
            m_pack[2*m_fill +: 2] = {po1, po0};
            m_fill++;
            n_acc++;
            if (m_total < 15) m_total++;
            if (m_fill == 4) begin
                q.push_back({m_pack, 3'd4});
                m_pack = '0;
                m_fill = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_pairs_total", pairs_total, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        q.delete();
        m_pack  = '0;
        m_fill  = 0;
        m_total = 0;
        drive(1'b0, 2'b00, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        drive(1'b0, 2'b00, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (q.size() > 0 || out_valid); k++) step();
        chk("drain_level", fifo_level, 0);
        chk("drain_queue", q.size(), 0);
    endtask

    initial begin
        int base;
        logic [1:0] p;

        do_reset();

        // Reset in the middle of a stream discards the partial word
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p = 2'(i + 1);
            drive(1'b1, p, 1'b0);
            step();
        end
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 1'b0); step();
        drive(1'b1, 2'b01, 1'b0); step();
        drive(1'b1, 2'b00, 1'b0); step();
        drive(1'b1, 2'b11, 1'b0); step();
        chk("t1_first_word", out_data, 8'hC6);
        drain();

        // Back-to-back packing
        drive(1'b1, 2'b01, 1'b0); step();
        drive(1'b1, 2'b10, 1'b0); step();
        drive(1'b1, 2'b11, 1'b0); step();
        drive(1'b1, 2'b00, 1'b0); step();
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 8'h39);
        chk("t2_count", out_count, 4);
        drain();

        // Backpressure: FIFO fills, last pair waits for space
        out_ready = 1'b0;
        base = n_acc;
        for (int i = 0; i < 20; i++) begin
            p = i[1:0];
            drive(1'b1, p ^ 2'b01, 1'b0);
            step();
        end
        chk("t3_accepted", n_acc - base, 19);
        chk("t3_level", fifo_level, 4);
        chk("t3_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("t3_ready_after_pop", in_ready, 1);
        chk("t3_not_yet", n_acc - base, 19);
        step();
        chk("t3_accepted_20", n_acc - base, 20);
        drain();

        // Flush of a partial word, then flush with nothing buffered
        drive(1'b1, 2'b11, 1'b0); step();
        drive(1'b1, 2'b01, 1'b0); step();
        drive(1'b0, 2'b00, 1'b1); step();
        drive(1'b0, 2'b00, 1'b0);
        exp_flush();
        step();
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 8'h07);
        chk("t4_count", out_count, 2);
        step();
        drive(1'b0, 2'b00, 1'b1); step();
        drive(1'b0, 2'b00, 1'b0); step();
        step();
        chk("t4_empty_flush_level", fifo_level, 0);
        chk("t4_empty_flush_valid", out_valid, 0);

        // Flush while the FIFO is full waits for space
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            p = i[1:0];
            drive(1'b1, ~p, 1'b0);
            step();
        end
        drive(1'b0, 2'b00, 1'b1); step();
        drive(1'b0, 2'b00, 1'b0); step();
        step();
        chk("t5_full_level", fifo_level, 4);
        exp_flush();
        out_ready = 1'b1;
        step();
        chk("t5_after_pop", fifo_level, 3);
        step();
        chk("t5_push_and_pop", fifo_level, 3);
        drain();

        // Accept and flush on the same edge
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 1'b0); step();
        drive(1'b1, 2'b10, 1'b1); step();
        drive(1'b0, 2'b00, 1'b0);
        exp_flush();
        step();
        chk("t6_valid", out_valid, 1);
        chk("t6_count", out_count, 2);
        chk("t6_slot1", out_data[3:2], 2'b10);
        step();
        step();
        chk("t6_single_word", fifo_level, 0);

        // pairs_total saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p = 2'(i * 3);
            drive(1'b1, p, 1'b0);
            step();
        end
        drive(1'b0, 2'b00, 1'b0);
        step();
        chk("t6_saturate", pairs_total, 4'hF);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
